// File: rtl/sram_resp_pkg.sv
// Shared types and byte-merge helper for the SRAM responder model.
package sram_resp_pkg;
  localparam int WORD_W = 32;
  localparam int STRB_W = 4;
  localparam int IDX_W  = 30;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wb_entry_t;

  function automatic logic [WORD_W-1:0] merge_bytes(input logic [WORD_W-1:0] base,
                                                     input logic [WORD_W-1:0] data,
                                                     input logic [STRB_W-1:0] strb);
    logic [WORD_W-1:0] res;
    res = base;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction
endpackage

// File: rtl/sram_resp_wbuf.sv
// In-order write buffer (circular FIFO) with a combinational forwarding port
// that merges every matching entry oldest-to-youngest.
module sram_resp_wbuf
  import sram_resp_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  wb_entry_t         push_entry_i,
  input  logic              pop_i,
  output wb_entry_t         head_o,
  output logic              full_o,
  output logic              empty_o,
  input  logic [IDX_W-1:0]  fwd_idx_i,
  output logic [WORD_W-1:0] fwd_data_o,
  output logic [STRB_W-1:0] fwd_hit_o
);

  wb_entry_t     ent_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] slot;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        ent_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      count_q <= count_q + 1'b1;
      else if (pop_i && !push_i) count_q <= count_q - 1'b1;
    end
  end

  assign head_o  = ent_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // Walk from head so younger strobes overwrite older ones per byte.
  always_comb begin
    fwd_data_o = '0;
    fwd_hit_o  = '0;
    slot       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && (ent_q[slot].idx == fwd_idx_i)) begin
        fwd_data_o = merge_bytes(fwd_data_o, ent_q[slot].data, ent_q[slot].strb);
        fwd_hit_o  = fwd_hit_o | ent_q[slot].strb;
      end
    end
  end

endmodule

// File: rtl/sram_resp_wbuf_mem.sv
// SRAM responder: backing array, write buffer with forwarding, RD_LAT read pipe.
// Optional out-of-range error reporting under SRAM_RESP_OOR_ERR_EN.
module sram_resp_wbuf_mem
  import sram_resp_pkg::*;
#(
  parameter int MEM_AW   = 12,
  parameter int RD_LAT   = 1,
  parameter int WB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic        sram_ready,
  output logic [31:0] sram_rdata,
  output logic        sram_rvalid
`ifdef SRAM_RESP_OOR_ERR_EN
  ,
  output logic        sram_err
`endif
);

  localparam int DEPTH = 1 << MEM_AW;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [MEM_AW-1:0] idx;
  logic              oor, acc, rd_acc, wr_acc, push, pop, full, empty;
  wb_entry_t         push_entry, head;
  logic [WORD_W-1:0] fwd_data, rd_word;
  logic [STRB_W-1:0] fwd_hit;
  logic [RD_LAT-1:0] vld_q;
  logic [WORD_W-1:0] data_q [RD_LAT];
  logic              unused_bits;

  assign idx = sram_addr[MEM_AW+1:2];
`ifdef SRAM_RESP_OOR_ERR_EN
  assign oor = |sram_addr[31:MEM_AW+2];
`else
  assign oor = 1'b0;
`endif
  assign unused_bits = ^{sram_addr[31:MEM_AW+2], sram_addr[1:0], head.idx[IDX_W-1:MEM_AW]};

  assign sram_ready = !full;
  assign acc        = sram_en && sram_ready;
  assign rd_acc     = acc && (sram_we == '0);
  assign wr_acc     = acc && (sram_we != '0);
  assign push       = wr_acc && !oor;
  // Drain only in cycles with no accepted request, so write bursts accumulate.
  assign pop        = !empty && !acc;
  assign push_entry = '{idx: IDX_W'(idx), data: sram_wdata, strb: sram_we};

  sram_resp_wbuf #(.DEPTH(WB_DEPTH)) u_wbuf (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .full_o       (full),
    .empty_o      (empty),
    .fwd_idx_i    (IDX_W'(idx)),
    .fwd_data_o   (fwd_data),
    .fwd_hit_o    (fwd_hit)
  );

  assign rd_word = oor ? '0 : merge_bytes(mem[idx], fwd_data, fwd_hit);

  always_ff @(posedge clk) begin
    if (!reset && pop)
      mem[head.idx[MEM_AW-1:0]] <= merge_bytes(mem[head.idx[MEM_AW-1:0]], head.data, head.strb);
  end

  // Data stages only load behind a valid, so the output holds between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) data_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_acc;
      if (rd_acc) data_q[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign sram_rvalid = vld_q[RD_LAT-1];
  assign sram_rdata  = data_q[RD_LAT-1];

`ifdef SRAM_RESP_OOR_ERR_EN
  logic [RD_LAT-1:0] err_q;
  logic              wr_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      err_q[0] <= rd_acc && oor;
      for (int i = 1; i < RD_LAT; i++) err_q[i] <= err_q[i-1];
      wr_err_q <= wr_acc && oor;
    end
  end

  assign sram_err = err_q[RD_LAT-1] | wr_err_q;
`endif

endmodule

// File: tb/tb_sram_resp_wbuf_mem.sv
// Directed bench for sram_resp_wbuf_mem (RD_LAT=3, WB_DEPTH=4, MEM_AW=12).
`timescale 1ns/1ps
module tb_sram_resp_wbuf_mem;
  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sram_en = 1'b0;
  logic [3:0]  sram_we = '0;
  logic [31:0] sram_addr = '0;
  logic [31:0] sram_wdata = '0;
  logic        sram_ready, sram_rvalid;
  logic [31:0] sram_rdata;
  logic        err_now;
`ifdef SRAM_RESP_OOR_ERR_EN
  logic        sram_err;
  assign err_now = sram_err;
`else
  assign err_now = 1'b0;
`endif

  sram_resp_wbuf_mem #(.MEM_AW(12), .RD_LAT(RD_LAT), .WB_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .sram_en     (sram_en),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_ready  (sram_ready),
    .sram_rdata  (sram_rdata),
    .sram_rvalid (sram_rvalid)
`ifdef SRAM_RESP_OOR_ERR_EN
    ,
    .sram_err    (sram_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } resp_t;
  resp_t rq[$];

  always @(negedge clk) begin
    if (sram_rvalid) begin
      resp_t r;
      r.cyc  = cyc;
      r.data = sram_rdata;
      r.err  = err_now;
      rq.push_back(r);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sram_en = 1'b0;
    sram_we = '0;
    repeat (n) step();
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!sram_ready && n < 50) begin
      step();
      n++;
    end
    if (!sram_ready) check({tag, "_ready_timeout"}, 32'(sram_ready), 32'd1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    sram_en = 1'b1; sram_we = s; sram_addr = a; sram_wdata = d;
    wait_ready("wr");
    step();
    sram_en = 1'b0; sram_we = '0;
  endtask

  task automatic rd(input logic [31:0] a, output int c);
    sram_en = 1'b1; sram_we = '0; sram_addr = a;
    wait_ready("rd");
    c = cyc;
    step();
    sram_en = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input int c_exp, input logic [31:0] d_exp,
                             input logic e_exp);
    int n = 0;
    resp_t r;
    while (rq.size() == 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (rq.size() == 0) begin
      check({tag, "_timeout"}, 32'(rq.size()), 32'd1);
    end else begin
      r = rq.pop_front();
      check({tag, "_lat"}, 32'(r.cyc), 32'(c_exp));
      check({tag, "_data"}, r.data, d_exp);
`ifdef SRAM_RESP_OOR_ERR_EN
      check({tag, "_err"}, 32'(r.err), 32'(e_exp));
`else
      if (e_exp) check({tag, "_err"}, 32'(r.err), 32'(e_exp));
`endif
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int c, c0, c1, c2;
    repeat (2) step();
    reset = 1'b0;
    check("rst_ready", 32'(sram_ready), 32'd1);
    check("rst_rvalid", 32'(sram_rvalid), 32'd0);
    check("rst_rdata", sram_rdata, 32'h0);

    // forwarding of a write accepted the cycle before
    wr(32'h100, 32'h11223344, 4'hF);
    rd(32'h100, c);
    expect_resp("t1", c + RD_LAT, 32'h11223344, 1'b0);
    idle(4);

    // two buffered writes to one word, youngest byte wins
    wr(32'h200, 32'hAAAAAAAA, 4'hF);
    wr(32'h200, 32'h000000BB, 4'h1);
    rd(32'h200, c);
    expect_resp("t2_fwd", c + RD_LAT, 32'hAAAAAABB, 1'b0);
    idle(4);
    rd(32'h200, c);
    expect_resp("t2_array", c + RD_LAT, 32'hAAAAAABB, 1'b0);

    // fill the buffer, stall, drain
    idle(2);
    for (int i = 0; i < 4; i++) begin
      wr(32'(32'h400 + 4 * i), 32'(32'hC0DE0000 + i), 4'hF);
      if (i == 2) check("t3_ready_at3", 32'(sram_ready), 32'd1);
    end
    check("t3_full", 32'(sram_ready), 32'd0);
    sram_en = 1'b1; sram_we = 4'hF; sram_addr = 32'h410; sram_wdata = 32'hC0DE0004;
    step();
    check("t3_ready_after_drain", 32'(sram_ready), 32'd1);
    step();
    sram_en = 1'b0; sram_we = '0;
    check("t3_full_again", 32'(sram_ready), 32'd0);
    idle(6);
    check("t3_empty_ready", 32'(sram_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      rd(32'(32'h400 + 4 * i), c);
      expect_resp($sformatf("t3_rd%0d", i), c + RD_LAT, 32'(32'hC0DE0000 + i), 1'b0);
    end

    // back-to-back reads through the pipeline
    wr(32'h0, 32'hA0A0A0A0, 4'hF);
    wr(32'h4, 32'hB1B1B1B1, 4'hF);
    wr(32'h8, 32'hC2C2C2C2, 4'hF);
    idle(5);
    rd(32'h0, c0);
    rd(32'h4, c1);
    rd(32'h8, c2);
    expect_resp("t4_r0", c0 + RD_LAT, 32'hA0A0A0A0, 1'b0);
    expect_resp("t4_r1", c1 + RD_LAT, 32'hB1B1B1B1, 1'b0);
    expect_resp("t4_r2", c2 + RD_LAT, 32'hC2C2C2C2, 1'b0);
    idle(5);
    check("t4_no_extra", 32'(rq.size()), 32'd0);

    // reset drops buffered writes and the in-flight read
    wr(32'h500, 32'h55550000, 4'hF);
    wr(32'h504, 32'h55551111, 4'hF);
    idle(4);
    wr(32'h500, 32'hDEAD0500, 4'hF);
    wr(32'h504, 32'hDEAD0504, 4'hF);
    rd(32'h500, c);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("t5_ready", 32'(sram_ready), 32'd1);
    check("t5_rvalid", 32'(sram_rvalid), 32'd0);
    check("t5_rdata", sram_rdata, 32'h0);
    idle(6);
    check("t5_no_rvalid", 32'(rq.size()), 32'd0);
    rd(32'h500, c);
    expect_resp("t5_old0", c + RD_LAT, 32'h55550000, 1'b0);
    rd(32'h504, c);
    expect_resp("t5_old1", c + RD_LAT, 32'h55551111, 1'b0);

`ifdef SRAM_RESP_OOR_ERR_EN
    rd(32'h0010_0000, c);
    expect_resp("t6_oor_rd", c + RD_LAT, 32'h0, 1'b1);
    idle(2);
    wr(32'h0010_0000, 32'h12345678, 4'hF);
    check("t6_wr_err", 32'(err_now), 32'd1);
    step();
    check("t6_wr_err_clr", 32'(err_now), 32'd0);
    idle(3);
    rd(32'h0, c);
    expect_resp("t6_not_pushed", c + RD_LAT, 32'hA0A0A0A0, 1'b0);
`else
    rd(32'h0010_0000, c);
    expect_resp("t6_alias_rd", c + RD_LAT, 32'hA0A0A0A0, 1'b0);
    wr(32'h0010_0004, 32'h77777777, 4'hF);
    idle(3);
    rd(32'h4, c);
    expect_resp("t6_alias_wr", c + RD_LAT, 32'h77777777, 1'b0);
`endif

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
